period_log_master: RTL and testbench
====================================

PERIOD_LOG_MASTER -- requirements
Module: period_log_master

Interface
REQ-001 The parameter ADDR_W SHALL default to 10 and set the word-address width of the target memory.
REQ-002 The parameter DEPTH SHALL default to 1024 and set the number of 32-bit words in the log buffer.
REQ-003 The parameter FIFO_DEPTH SHALL default to 4 and set the number of pending samples held before memory write.
REQ-004 clk  in  1  the single clock; every register is clocked on its rising edge.
REQ-005 reset  in  1  reset; synchronous and active-high.
REQ-006 enable  in  1  when high, periods are captured; when low, capture stops and the FIFO drains.
REQ-007 clear  in  1  single-cycle pulse that empties the log and clears status.
REQ-008 event_in  in  1  event input, already synchronous to clk; only rising edges are significant.
REQ-009 avm_address  out  ADDR_W  Avalon-MM word address.
REQ-010 avm_chipselect  out  1  Avalon-MM chip select.
REQ-011 avm_write  out  1  Avalon-MM write strobe.
REQ-012 avm_writedata  out  32  Avalon-MM write data, carrying the period in clk cycles.
REQ-013 avm_byteenable  out  4  Avalon-MM byte enables; always 4'hF while avm_write is high.
REQ-014 avm_waitrequest  in  1  Avalon-MM stall; tie to 0 when driving on-chip RAM.
REQ-015 wr_ptr  out  ADDR_W  next memory word to be written.
REQ-016 words_logged  out  32  total number of accepted writes; saturates at 0xFFFF_FFFF.
REQ-017 overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-018 buf_full  out  1  buffer exhausted (no-wrap build only; otherwise constant 0).
REQ-019 wrapped  out  1  sticky flag: wr_ptr has wrapped from DEPTH-1 to 0.

Function
REQ-020 Edge detection SHALL fire on the first cycle in which event_in is 1, given it was 0 in the previous cycle.
REQ-021 The 32-bit period counter SHALL increment by one per clk cycle and saturate at 0xFFFF_FFFF; each edge restarts it at 1.
REQ-022 The first edge after reset, after clear, or after enable rises SHALL only arm capture; no sample is pushed.
REQ-023 Each subsequent edge SHALL push the cycle distance between consecutive edges into the FIFO (edges at cycles 5 and 15 push 10).
REQ-024 An edge that arrives with the FIFO full SHALL discard its sample and set overflow.
REQ-025 The write state machine SHALL have two states, IDLE and WRITE.
REQ-026 From IDLE, when the FIFO is non-empty and buf_full is 0, the FSM SHALL move to WRITE, driving avm_chipselect=1, avm_write=1, avm_address=wr_ptr, avm_writedata=FIFO head.
REQ-027 In WRITE, all Avalon outputs SHALL be held stable while avm_waitrequest is 1.
REQ-028 In the first WRITE cycle with avm_waitrequest=0, the FSM SHALL pop the FIFO, increment wr_ptr and words_logged, and return to IDLE; minimum cost is 2 cycles per word.
REQ-029 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-030 The Avalon outputs SHALL be 0 whenever the FSM is in IDLE.
REQ-031 When clear asserts during WRITE, the clear SHALL be held pending, the transfer SHALL complete, and the clear SHALL take effect in the following IDLE cycle.
REQ-032 When clear takes effect, it SHALL zero wr_ptr, words_logged, overflow, wrapped, buf_full, and the FIFO, and SHALL disarm capture.
REQ-033 enable low SHALL block pushes and disarm capture, but SHALL NOT block FIFO draining.

Reset
REQ-034 reset SHALL force the FSM to IDLE and all outputs, the FIFO, the period counter, the arm flag and the pending-clear flag to 0, including during a WRITE in progress.

Configuration
REQ-035 With PERIOD_LOG_WRAP_EN defined, a write at DEPTH-1 SHALL set wr_ptr to 0 and set wrapped, and logging SHALL continue.
REQ-036 Without PERIOD_LOG_WRAP_EN, a write at DEPTH-1 SHALL set buf_full, leave wr_ptr at DEPTH-1, and stop all further pushes and writes until clear; wrapped stays 0.

Structure
REQ-037 The package period_log_pkg SHALL hold the state enum (IDLE, WRITE), the 32-bit sample typedef, and the defaults for ADDR_W and DEPTH.
REQ-038 The FIFO SHALL be the sub-module period_log_fifo (synchronous, FIFO_DEPTH entries, push/pop/full/empty).

Verification
REQ-039 Scenario: edges at cycles 10, 20, 33 with waitrequest=0 -> writes 10 to addr 0 and 13 to addr 1; words_logged=2.
REQ-040 Scenario: waitrequest held high for 5 cycles during a write -> address and data are stable throughout; exactly one write is counted.
REQ-041 Scenario: waitrequest high while 6 edges arrive -> 4 samples are stored in order; overflow=1.
REQ-042 Scenario: DEPTH=4 with the wrap build -> the 5th sample goes to addr 0 and wrapped=1; the no-wrap build sets buf_full=1 after the 4th sample with no 5th write.
REQ-043 Scenario: clear asserted in mid-WRITE -> the current write completes, then wr_ptr=0, words_logged=0, and the next edge only arms capture.
REQ-044 Scenario: reset asserted in mid-WRITE -> avm_write=0 on the next cycle and all status outputs read 0.

Source files
------------

// File: rtl/period_log_pkg.sv
// Shared types and defaults for the period logger.
package period_log_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1024;

    typedef logic [31:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam sample_t SAT_MAX = 32'hFFFF_FFFF;

    function automatic sample_t sat_inc(sample_t v);
        return (v == SAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/period_log_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is rejected even if a pop coincides.
module period_log_fifo
    import period_log_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    input  logic    push,
    input  sample_t din,
    input  logic    pop,
    output sample_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    sample_t       mem_q [FIFO_DEPTH];
    sample_t       mem_d [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rp_q];

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wp_q] = din;
                wp_d = (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_d = (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/period_log_master.sv
// Measures event_in periods and logs them to memory over Avalon-MM.
// Define PERIOD_LOG_WRAP_EN to make the log a ring instead of stopping when full.
module period_log_master
    import period_log_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              event_in,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [31:0]       words_logged,
    output logic              overflow,
    output logic              buf_full,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              ev_q, ev_d;
    sample_t           cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    sample_t           words_q, words_d;
    logic              ovf_q, ovf_d;
    logic              wrapped_q, wrapped_d;
    logic              full_q, full_d;

    logic    ev_rise, clr_now;
    logic    f_push, f_pop, f_flush, f_full, f_empty;
    sample_t f_dout;

    period_log_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (f_flush),
        .push  (f_push),
        .din   (cnt_q),
        .pop   (f_pop),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    assign wr_ptr       = wr_ptr_q;
    assign words_logged = words_q;
    assign overflow     = ovf_q;
    assign buf_full     = full_q;
    assign wrapped      = wrapped_q;

    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        clr_pend_d     = clr_pend_q;
        wr_ptr_d       = wr_ptr_q;
        words_d        = words_q;
        ovf_d          = ovf_q;
        wrapped_d      = wrapped_q;
        full_d         = full_q;
        f_push         = 1'b0;
        f_pop          = 1'b0;
        f_flush        = 1'b0;
        avm_address    = '0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        avm_byteenable = 4'h0;

        ev_d    = event_in;
        ev_rise = event_in && !ev_q;
        cnt_d   = ev_rise ? 32'd1 : sat_inc(cnt_q);
        // A clear raised mid-transfer waits for the bus to go idle.
        clr_now = (state_q == IDLE) && (clear || clr_pend_q);

        if (ev_rise && enable && armed_q && !clr_now && !full_q) begin
            if (f_full) begin
                ovf_d = 1'b1;
            end else begin
                f_push = 1'b1;
            end
        end

        if (!enable || clr_now) begin
            armed_d = 1'b0;
        end else if (ev_rise) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                clr_pend_d = 1'b0;
                if (clr_now) begin
                    f_flush   = 1'b1;
                    wr_ptr_d  = '0;
                    words_d   = '0;
                    ovf_d     = 1'b0;
                    wrapped_d = 1'b0;
                    full_d    = 1'b0;
                end else if (!f_empty && !full_q) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                avm_address    = wr_ptr_q;
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_writedata  = f_dout;
                avm_byteenable = 4'hF;
                clr_pend_d     = clr_pend_q || clear;
                if (!avm_waitrequest) begin
                    f_pop   = 1'b1;
                    words_d = sat_inc(words_q);
                    state_d = IDLE;
                    if (wr_ptr_q == LAST) begin
`ifdef PERIOD_LOG_WRAP_EN
                        wr_ptr_d  = '0;
                        wrapped_d = 1'b1;
`else
                        full_d    = 1'b1;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ev_q       <= 1'b0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            wrapped_q  <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_q       <= ev_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            clr_pend_q <= clr_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            wrapped_q  <= wrapped_d;
            full_q     <= full_d;
        end
    end

endmodule

// File: tb/tb_period_log_master.sv
// Randomized and directed bench for period_log_master against a queue-based model.
module tb_period_log_master;

    localparam int AW = 2;
    localparam int DP = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset, enable, clear, event_in, avm_waitrequest;
    logic [AW-1:0] avm_address, wr_ptr;
    logic          avm_chipselect, avm_write;
    logic [31:0]   avm_writedata, words_logged;
    logic [3:0]    avm_byteenable;
    logic          overflow, buf_full, wrapped;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    period_log_master #(.ADDR_W(AW), .DEPTH(DP), .FIFO_DEPTH(FD)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .event_in        (event_in),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .wr_ptr          (wr_ptr),
        .words_logged    (words_logged),
        .overflow        (overflow),
        .buf_full        (buf_full),
        .wrapped         (wrapped)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sample is the cycle distance between armed edges; the queue is the FIFO.
    longint      cyc = 0;
    longint      last_edge = 0;
    bit          m_prev, m_armed, m_busy, m_pend, m_ovf, m_wrp, m_full;
    int          m_wp;
    longint      m_words;
    int unsigned mq[$];
    int          pre;
    bit          rise, cnow;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_prev = 0; m_armed = 0; m_busy = 0; m_pend = 0;
            m_ovf = 0; m_wrp = 0; m_full = 0; m_wp = 0; m_words = 0;
            mq.delete();
        end else begin
            rise   = event_in && !m_prev;
            m_prev = event_in;
            pre    = mq.size();
            cnow   = !m_busy && (clear || m_pend);
            if (rise && enable && m_armed && !cnow && !m_full) begin
                if (pre == FD) m_ovf = 1;
                else mq.push_back(int'(cyc - last_edge));
            end
            if (rise) last_edge = cyc;
            if (!enable || cnow) m_armed = 0;
            else if (rise) m_armed = 1;
            if (m_busy) begin
                m_pend = m_pend || clear;
                if (!avm_waitrequest) begin
                    void'(mq.pop_front());
                    m_words++;
                    m_busy = 0;
                    if (m_wp == DP - 1) begin
`ifdef PERIOD_LOG_WRAP_EN
                        m_wp = 0;
                        m_wrp = 1;
`else
                        m_full = 1;
`endif
                    end else begin
                        m_wp++;
                    end
                end
            end else if (cnow) begin
                m_pend = 0; m_ovf = 0; m_wrp = 0; m_full = 0;
                m_wp = 0; m_words = 0;
                mq.delete();
            end else if (pre > 0 && !m_full) begin
                m_busy = 1;
            end
        end
    end

    int          obs_a[$];
    int unsigned obs_d[$];

    always @(negedge clk) begin
        chk("cs", 64'(avm_chipselect), 64'(m_busy));
        chk("write", 64'(avm_write), 64'(m_busy));
        chk("addr", 64'(avm_address), 64'(m_busy ? m_wp : 0));
        chk("data", 64'(avm_writedata), 64'(m_busy ? mq[0] : 0));
        chk("be", 64'(avm_byteenable), 64'(m_busy ? 4'hF : 4'h0));
        chk("wr_ptr", 64'(wr_ptr), 64'(m_wp));
        chk("words", 64'(words_logged), 64'(m_words));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("buf_full", 64'(buf_full), 64'(m_full));
        chk("wrapped", 64'(wrapped), 64'(m_wrp));
        if (avm_write && !avm_waitrequest) begin
            obs_a.push_back(int'(avm_address));
            obs_d.push_back(avm_writedata);
        end
    end

    function automatic longint oa(int i);
        return (i < obs_a.size()) ? longint'(obs_a[i]) : -1;
    endfunction

    function automatic longint od(int i);
        return (i < obs_d.size()) ? longint'(obs_d[i]) : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scn();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enable = 1'b1;
        clear = 1'b0;
        event_in = 1'b0;
        avm_waitrequest = 1'b0;
        obs_a.delete();
        obs_d.delete();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        clear = 1'b0;
        event_in = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (3) tick();
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_words", 64'(words_logged), 64'd0);
        chk("rst_write", 64'(avm_write), 64'd0);

        // Edges at 10, 20, 33.
        start_scn();
        for (int k = 0; k < 50; k++) begin
            event_in = (k == 10 || k == 20 || k == 33);
            tick();
        end
        chk("s1_n", 64'(obs_a.size()), 64'd2);
        chk("s1_a0", 64'(oa(0)), 64'd0);
        chk("s1_d0", 64'(od(0)), 64'd10);
        chk("s1_a1", 64'(oa(1)), 64'd1);
        chk("s1_d1", 64'(od(1)), 64'd13);
        chk("s1_words", 64'(words_logged), 64'd2);

        // Waitrequest stalls the write for five cycles.
        start_scn();
        for (int k = 0; k < 25; k++) begin
            event_in = (k == 2 || k == 9);
            avm_waitrequest = (k < 16);
            tick();
        end
        chk("s2_n", 64'(obs_a.size()), 64'd1);
        chk("s2_d0", 64'(od(0)), 64'd7);
        chk("s2_words", 64'(words_logged), 64'd1);

        // Overflow while stalled, then the buffer end.
        start_scn();
        for (int k = 0; k < 70; k++) begin
            event_in = (k inside {1, 3, 6, 10, 15, 21, 28, 50});
            avm_waitrequest = (k < 32);
            tick();
        end
        chk("s3_ovf", 64'(overflow), 64'd1);
        chk("s3_d0", 64'(od(0)), 64'd2);
        chk("s3_d1", 64'(od(1)), 64'd3);
        chk("s3_d2", 64'(od(2)), 64'd4);
        chk("s3_d3", 64'(od(3)), 64'd5);
        chk("s3_a3", 64'(oa(3)), 64'd3);
`ifdef PERIOD_LOG_WRAP_EN
        chk("s3_n", 64'(obs_a.size()), 64'd5);
        chk("s3_a4", 64'(oa(4)), 64'd0);
        chk("s3_d4", 64'(od(4)), 64'd22);
        chk("s3_wrapped", 64'(wrapped), 64'd1);
        chk("s3_full", 64'(buf_full), 64'd0);
        chk("s3_words", 64'(words_logged), 64'd5);
`else
        chk("s3_n", 64'(obs_a.size()), 64'd4);
        chk("s3_wrapped", 64'(wrapped), 64'd0);
        chk("s3_full", 64'(buf_full), 64'd1);
        chk("s3_wr_ptr", 64'(wr_ptr), 64'd3);
        chk("s3_words", 64'(words_logged), 64'd4);
`endif

        // Clear raised during a stalled write.
        start_scn();
        for (int k = 0; k < 45; k++) begin
            if (k == 22) begin
                chk("s4_mid_words", 64'(words_logged), 64'd0);
                chk("s4_mid_ptr", 64'(wr_ptr), 64'd0);
                chk("s4_mid_n", 64'(obs_a.size()), 64'd1);
            end
            event_in = (k inside {2, 8, 25, 30});
            clear = (k == 13);
            avm_waitrequest = (k < 17);
            tick();
        end
        chk("s4_d0", 64'(od(0)), 64'd6);
        chk("s4_n", 64'(obs_a.size()), 64'd2);
        chk("s4_a1", 64'(oa(1)), 64'd0);
        chk("s4_d1", 64'(od(1)), 64'd5);
        chk("s4_words", 64'(words_logged), 64'd1);

        // Reset during a stalled write.
        start_scn();
        for (int k = 0; k < 12; k++) begin
            event_in = (k == 2 || k == 5);
            avm_waitrequest = 1'b1;
            tick();
        end
        chk("s5_busy", 64'(avm_write), 64'd1);
        chk("s5_data", 64'(avm_writedata), 64'd3);
        reset = 1'b1;
        tick();
        chk("s5_write", 64'(avm_write), 64'd0);
        chk("s5_cs", 64'(avm_chipselect), 64'd0);
        chk("s5_words", 64'(words_logged), 64'd0);
        chk("s5_ptr", 64'(wr_ptr), 64'd0);
        reset = 1'b0;

        // Random traffic.
        start_scn();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 19) != 0);
            clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) event_in = ~event_in;
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
